// File: rtl/fault_mon_pkg.sv
// Shared types, error_code bit map, default configuration and word-level check helpers
// for the multi-channel sensor fault monitor.
package fault_mon_pkg;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    SUSPECT = 2'd1,
    FAULT   = 2'd2,
    RECOVER = 2'd3
  } health_e;

  localparam int ERR_CSUM  = 0;
  localparam int ERR_RANGE = 1;
  localparam int ERR_LOSS  = 2;
  localparam int ERR_FAULT = 3;
  localparam int ERR_W     = 4;

  localparam int DEF_NUM_SENSORS = 3;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_NUM_WORDS   = 15;
  localparam int DEF_RANGE_MIN   = -10000;
  localparam int DEF_RANGE_MAX   = 10000;
  localparam int DEF_FAULT_CNT   = 3;
  localparam int DEF_RECOVER_CNT = 8;
  localparam int DEF_STUCK_CNT   = 4;

  // Helpers work on words widened to MAX_DW, so DATA_WIDTH may be anything up to 32.
  localparam int MAX_DW = 32;
  localparam logic [MAX_DW:0] ONE_X = 1;

  function automatic logic [MAX_DW-1:0] width_mask(input int dw);
    logic [MAX_DW:0] m;
    m = (ONE_X << dw) - ONE_X;
    return m[MAX_DW-1:0];
  endfunction

  function automatic logic [MAX_DW-1:0] csum_add(input logic [MAX_DW-1:0] acc,
                                                  input logic [MAX_DW-1:0] word,
                                                  input int dw);
    return (acc + word) & width_mask(dw);
  endfunction

  function automatic logic word_out_of_range(input logic signed [MAX_DW-1:0] word,
                                             input int lo,
                                             input int hi);
    return (word < lo) || (word > hi);
  endfunction

endpackage

// File: rtl/sensor_health_fsm.sv
// Per-channel persistence/recovery tracker; state and counter update on the edge after a
// valid frame, channels without a frame hold. Reset parks the channel in RECOVER.
module sensor_health_fsm
  import fault_mon_pkg::*;
#(
  parameter int FAULT_CNT   = DEF_FAULT_CNT,
  parameter int RECOVER_CNT = DEF_RECOVER_CNT
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    frame_valid,
  input  logic    bad,
  output health_e state,
  output health_e state_nxt,
  output logic    enter_fault
);

  localparam int MAX_CNT = (FAULT_CNT > RECOVER_CNT) ? FAULT_CNT : RECOVER_CNT;
  localparam int CW      = $clog2(MAX_CNT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RECOVER;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_inc = (cnt_q == CW'(MAX_CNT)) ? cnt_q : cnt_q + 1'b1;

  // One shared counter: it counts bad frames in SUSPECT and good frames in RECOVER.
  always_comb begin
    state_nxt = state;
    cnt_d     = cnt_q;
    if (frame_valid) begin
      unique case (state)
        OK: begin
          if (bad) begin
            if (FAULT_CNT <= 1) begin
              state_nxt = FAULT;
              cnt_d     = '0;
            end else begin
              state_nxt = SUSPECT;
              cnt_d     = CW'(1);
            end
          end
        end
        SUSPECT: begin
          if (!bad) begin
            state_nxt = OK;
            cnt_d     = '0;
          end else if (cnt_inc >= CW'(FAULT_CNT)) begin
            state_nxt = FAULT;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        FAULT: begin
          if (!bad) begin
            if (RECOVER_CNT <= 1) begin
              state_nxt = OK;
              cnt_d     = '0;
            end else begin
              state_nxt = RECOVER;
              cnt_d     = CW'(1);
            end
          end
        end
        RECOVER: begin
          if (bad) begin
            state_nxt = FAULT;
            cnt_d     = '0;
          end else if (cnt_inc >= CW'(RECOVER_CNT)) begin
            state_nxt = OK;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_nxt = RECOVER;
          cnt_d     = '0;
        end
      endcase
    end
  end

  assign enter_fault = (state_nxt == FAULT) && (state != FAULT);

endmodule

// File: rtl/fault_monitor_nch.sv
// N-channel sensor fault monitor: checksum/range/loss checks, per-channel health FSM, fault mask,
// sticky error history and FAULT irq; 1-cycle latency. FAULT_MON_STUCK_DETECT_EN adds stuck detection.
module fault_monitor_nch
  import fault_mon_pkg::*;
#(
  parameter int NUM_SENSORS = DEF_NUM_SENSORS,
`ifdef FAULT_MON_STUCK_DETECT_EN
  parameter int STUCK_CNT   = DEF_STUCK_CNT,
`endif
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_WORDS   = DEF_NUM_WORDS,
  parameter int RANGE_MIN   = DEF_RANGE_MIN,
  parameter int RANGE_MAX   = DEF_RANGE_MAX,
  parameter int FAULT_CNT   = DEF_FAULT_CNT,
  parameter int RECOVER_CNT = DEF_RECOVER_CNT
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic [NUM_SENSORS-1:0]                                  frame_valid,
  input  logic [NUM_SENSORS-1:0][DATA_WIDTH*(NUM_WORDS+1)-1:0]    sensor_data,
  input  logic                                                    clear_sticky,
  output logic [NUM_SENSORS-1:0][1:0]                             health_state,
  output logic [NUM_SENSORS-1:0]                                  fault_mask,
  output logic [NUM_SENSORS-1:0]                                  stuck_flags,
  output logic [ERR_W-1:0]                                        error_code,
  output logic [ERR_W-1:0]                                        sticky_code,
  output logic                                                    irq
);

  localparam int PAY_W = DATA_WIDTH * NUM_WORDS;

  logic [NUM_SENSORS-1:0][ERR_LOSS:ERR_CSUM] flags_d;
  logic [NUM_SENSORS-1:0]                    in_fault_d;
  logic [NUM_SENSORS-1:0]                    enter_fault;
  logic [ERR_W-1:0]                          err_d;

  for (genvar c = 0; c < NUM_SENSORS; c++) begin : g_ch
    logic [MAX_DW-1:0]       sum_acc;
    logic                    rng_acc;
    logic                    ch_loss;
    logic                    ch_csum;
    logic                    ch_range;
    logic                    ch_stuck;
    logic                    ch_bad;
    logic [ERR_LOSS:ERR_CSUM] ch_flags_q;
    logic [ERR_LOSS:ERR_CSUM] ch_flags_new;
    health_e                 ch_state;
    health_e                 ch_state_nxt;
    logic                    ch_enter;

    always_comb begin
      sum_acc = '0;
      rng_acc = 1'b0;
      for (int w = 0; w < NUM_WORDS; w++) begin
        sum_acc = csum_add(sum_acc, MAX_DW'(sensor_data[c][w*DATA_WIDTH +: DATA_WIDTH]), DATA_WIDTH);
        if (word_out_of_range(MAX_DW'($signed(sensor_data[c][w*DATA_WIDTH +: DATA_WIDTH])),
                              RANGE_MIN, RANGE_MAX)) begin
          rng_acc = 1'b1;
        end
      end
    end

    // An all-zero frame is a lost signal, not a checksum or range failure.
    assign ch_loss  = (sensor_data[c] == '0);
    assign ch_csum  = !ch_loss && (sum_acc != MAX_DW'(sensor_data[c][PAY_W +: DATA_WIDTH]));
    assign ch_range = !ch_loss && rng_acc;

`ifdef FAULT_MON_STUCK_DETECT_EN
    localparam int SCW = $clog2(STUCK_CNT + 1);
    logic [PAY_W-1:0] last_pay;
    logic [SCW-1:0]   run_cnt;
    logic [SCW-1:0]   run_nxt;
    logic             same_pay;
    logic             stuck_q;

    assign same_pay = (run_cnt != '0) && (sensor_data[c][PAY_W-1:0] == last_pay);
    assign run_nxt  = !same_pay ? SCW'(1) :
                      (run_cnt == SCW'(STUCK_CNT)) ? run_cnt : run_cnt + 1'b1;
    assign ch_stuck = frame_valid[c] && !ch_loss && (run_nxt >= SCW'(STUCK_CNT));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        last_pay <= '0;
        run_cnt  <= '0;
        stuck_q  <= 1'b0;
      end else if (frame_valid[c] && !ch_loss) begin
        last_pay <= sensor_data[c][PAY_W-1:0];
        run_cnt  <= run_nxt;
        stuck_q  <= ch_stuck;
      end
    end

    assign stuck_flags[c] = stuck_q;
`else
    assign ch_stuck       = 1'b0;
    assign stuck_flags[c] = 1'b0;
`endif

    assign ch_bad = ch_loss || ch_csum || ch_range || ch_stuck;

    always_comb begin
      ch_flags_new           = '0;
      ch_flags_new[ERR_CSUM]  = ch_csum;
      ch_flags_new[ERR_RANGE] = ch_range;
      ch_flags_new[ERR_LOSS]  = ch_loss;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ch_flags_q <= '0;
      end else if (frame_valid[c]) begin
        ch_flags_q <= ch_flags_new;
      end
    end

    assign flags_d[c] = frame_valid[c] ? ch_flags_new : ch_flags_q;

    sensor_health_fsm #(
      .FAULT_CNT   (FAULT_CNT),
      .RECOVER_CNT (RECOVER_CNT)
    ) u_fsm (
      .clk         (clk),
      .rst         (rst),
      .frame_valid (frame_valid[c]),
      .bad         (ch_bad),
      .state       (ch_state),
      .state_nxt   (ch_state_nxt),
      .enter_fault (ch_enter)
    );

    assign health_state[c] = ch_state;
    assign fault_mask[c]   = (ch_state == FAULT) || (ch_state == RECOVER);
    assign in_fault_d[c]   = (ch_state_nxt == FAULT);
    assign enter_fault[c]  = ch_enter;
  end

  always_comb begin
    err_d = '0;
    for (int c = 0; c < NUM_SENSORS; c++) begin
      err_d[ERR_LOSS:ERR_CSUM] = err_d[ERR_LOSS:ERR_CSUM] | flags_d[c];
    end
    err_d[ERR_FAULT] = |in_fault_d;
  end

  // A clear pulse coinciding with a fresh error keeps the fresh error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_code  <= '0;
      sticky_code <= '0;
      irq         <= 1'b0;
    end else begin
      error_code  <= err_d;
      sticky_code <= (clear_sticky ? '0 : sticky_code) | err_d;
      irq         <= |enter_fault;
    end
  end

endmodule

// File: tb/tb_fault_monitor_nch.sv
// Directed bench for fault_monitor_nch with a behavioural model feeding an expected-result queue.
module tb_fault_monitor_nch;

  localparam int NS = 3;
  localparam int DW = 16;
  localparam int NW = 15;
  localparam int FW = DW * (NW + 1);
  localparam int FC = 3;
  localparam int RC = 8;
`ifdef FAULT_MON_STUCK_DETECT_EN
  localparam int SC = 4;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NS-1:0]          frame_valid;
  logic [NS-1:0][FW-1:0]  sensor_data;
  logic                   clear_sticky;
  logic [NS-1:0][1:0]     health_state;
  logic [NS-1:0]          fault_mask;
  logic [NS-1:0]          stuck_flags;
  logic [3:0]             error_code;
  logic [3:0]             sticky_code;
  logic                   irq;

  fault_monitor_nch dut (
    .clk          (clk),
    .rst          (rst),
    .frame_valid  (frame_valid),
    .sensor_data  (sensor_data),
    .clear_sticky (clear_sticky),
    .health_state (health_state),
    .fault_mask   (fault_mask),
    .stuck_flags  (stuck_flags),
    .error_code   (error_code),
    .sticky_code  (sticky_code),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0][1:0] hs;
    logic [NS-1:0]      mask;
    logic [NS-1:0]      stuck;
    logic [3:0]         ec;
    logic [3:0]         sc;
    logic               irq;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int            m_st  [NS];
  int            m_cnt [NS];
  logic [2:0]    m_flg [NS];
  logic [NS-1:0] m_stuck;
  logic [3:0]    m_sticky;
`ifdef FAULT_MON_STUCK_DETECT_EN
  logic [DW*NW-1:0] m_last [NS];
  int               m_run  [NS];
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk_frame(input int seed, input int bad_idx,
                                             input logic [DW-1:0] bad_val, input int cs_delta);
    logic [FW-1:0] f;
    logic [DW-1:0] w;
    logic [DW-1:0] sum;
    f   = '0;
    sum = '0;
    for (int i = 0; i < NW; i++) begin
      w = DW'((seed * 37 + i * 211) % 4096);
      if (i == bad_idx) w = bad_val;
      f[i*DW +: DW] = w;
      sum = sum + w;
    end
    f[NW*DW +: DW] = sum + DW'(cs_delta);
    return f;
  endfunction

  // Returns {loss, range, checksum}.
  function automatic logic [2:0] eval(input logic [FW-1:0] f);
    logic [DW-1:0] sum;
    logic          rng;
    int            sv;
    if (f == '0) return 3'b100;
    sum = '0;
    rng = 1'b0;
    for (int i = 0; i < NW; i++) begin
      sum = sum + f[i*DW +: DW];
      sv  = int'($signed(f[i*DW +: DW]));
      if (sv < -10000 || sv > 10000) rng = 1'b1;
    end
    return {1'b0, rng, sum != f[NW*DW +: DW]};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NS; c++) begin
      m_st[c]  = 3;
      m_cnt[c] = 0;
      m_flg[c] = '0;
`ifdef FAULT_MON_STUCK_DETECT_EN
      m_last[c] = '0;
      m_run[c]  = 0;
`endif
    end
    m_stuck  = '0;
    m_sticky = '0;
  endtask

  task automatic drive(input logic [NS-1:0] v, input logic [NS-1:0][FW-1:0] d, input logic clr);
    exp_t       e;
    logic [2:0] fl;
    logic       bad;
    logic       entered;
    logic [3:0] ec;
    int         prev;
    frame_valid  = v;
    sensor_data  = d;
    clear_sticky = clr;
    entered      = 1'b0;
    for (int c = 0; c < NS; c++) begin
      if (v[c]) begin
        fl  = eval(d[c]);
        bad = |fl;
`ifdef FAULT_MON_STUCK_DETECT_EN
        if (!fl[2]) begin
          if (m_run[c] != 0 && d[c][DW*NW-1:0] == m_last[c]) m_run[c] = (m_run[c] < SC) ? m_run[c] + 1 : m_run[c];
          else m_run[c] = 1;
          m_last[c]  = d[c][DW*NW-1:0];
          m_stuck[c] = (m_run[c] >= SC);
          bad = bad | m_stuck[c];
        end
`endif
        m_flg[c] = fl;
        prev = m_st[c];
        case (m_st[c])
          0: if (bad) begin
               if (FC == 1) m_st[c] = 2;
               else begin m_st[c] = 1; m_cnt[c] = 1; end
             end
          1: if (bad) begin
               m_cnt[c]++;
               if (m_cnt[c] >= FC) begin m_st[c] = 2; m_cnt[c] = 0; end
             end else begin
               m_st[c] = 0; m_cnt[c] = 0;
             end
          2: if (!bad) begin
               if (RC == 1) m_st[c] = 0;
               else begin m_st[c] = 3; m_cnt[c] = 1; end
             end
          default: if (bad) begin
               m_st[c] = 2; m_cnt[c] = 0;
             end else begin
               m_cnt[c]++;
               if (m_cnt[c] >= RC) begin m_st[c] = 0; m_cnt[c] = 0; end
             end
        endcase
        if (m_st[c] == 2 && prev != 2) entered = 1'b1;
      end
    end
    ec = '0;
    for (int c = 0; c < NS; c++) begin
      ec[2:0] = ec[2:0] | m_flg[c];
      if (m_st[c] == 2) ec[3] = 1'b1;
    end
    m_sticky = (clr ? 4'b0 : m_sticky) | ec;
    for (int c = 0; c < NS; c++) begin
      e.hs[c]   = 2'(m_st[c]);
      e.mask[c] = (m_st[c] >= 2);
    end
    e.stuck = m_stuck;
    e.ec    = ec;
    e.sc    = m_sticky;
    e.irq   = entered;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("health_state", 32'(health_state), 32'(e.hs));
    check("fault_mask",   32'(fault_mask),   32'(e.mask));
    check("stuck_flags",  32'(stuck_flags),  32'(e.stuck));
    check("error_code",   32'(error_code),   32'(e.ec));
    check("sticky_code",  32'(sticky_code),  32'(e.sc));
    check("irq",          32'(irq),          32'(e.irq));
    frame_valid  = '0;
    clear_sticky = 1'b0;
  endtask

  initial begin
    logic [NS-1:0][FW-1:0] d;
    logic [1:0]            st_seen [FC];
    int                    irq_cnt;

    rst          = 1'b1;
    frame_valid  = '0;
    sensor_data  = '0;
    clear_sticky = 1'b0;
    d            = '0;
    model_reset();
    #1;
    check("reset_health_state", 32'(health_state), 32'h3f);
    check("reset_fault_mask",   32'(fault_mask),   32'h7);
    check("reset_error_code",   32'(error_code),   32'h0);
    check("reset_sticky_code",  32'(sticky_code),  32'h0);
    check("reset_irq",          32'(irq),          32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Bring every channel out of RECOVER.
    for (int k = 0; k < RC; k++) begin
      d[0] = mk_frame(k + 1, -1, '0, 0);
      d[1] = mk_frame(k + 20, -1, '0, 0);
      d[2] = mk_frame(k + 40, -1, '0, 0);
      drive(3'b111, d, 1'b0);
      if (k == RC - 2) begin
        check("t1_ch0_still_recover", 32'(health_state[0]), 32'd3);
        check("t1_ch0_still_masked",  32'(fault_mask[0]),   32'd1);
      end
    end
    check("t1_ch0_ok",       32'(health_state[0]), 32'd0);
    check("t1_ch0_unmasked", 32'(fault_mask[0]),   32'd0);

    // Checksum off by one on ch1, three frames in a row.
    irq_cnt = 0;
    for (int k = 0; k < FC; k++) begin
      d[1] = mk_frame(60 + k, -1, '0, 1);
      drive(3'b010, d, 1'b0);
      st_seen[k] = health_state[1];
      if (irq) irq_cnt++;
    end
    check("t2_state_0", 32'(st_seen[0]), 32'd1);
    check("t2_state_1", 32'(st_seen[1]), 32'd1);
    check("t2_state_2", 32'(st_seen[2]), 32'd2);
    check("t2_err_csum",  32'(error_code[0]), 32'd1);
    check("t2_err_fault", 32'(error_code[3]), 32'd1);
    drive(3'b000, d, 1'b0);
    if (irq) irq_cnt++;
    check("t2_irq_pulses", 32'(irq_cnt), 32'd1);

    // Out-of-range word on ch2, then a good frame.
    d[2] = mk_frame(70, 5, 16'd10001, 0);
    drive(3'b100, d, 1'b0);
    check("t3_err_range", 32'(error_code[1]),   32'd1);
    check("t3_ch2_susp",  32'(health_state[2]), 32'd1);
    d[2] = mk_frame(71, -1, '0, 0);
    drive(3'b100, d, 1'b0);
    check("t3_ch2_ok",         32'(health_state[2]), 32'd0);
    check("t3_sticky_range",   32'(sticky_code[1]),  32'd1);

    // Recover ch1 so only ch0 contributes next.
    for (int k = 0; k < RC; k++) begin
      d[1] = mk_frame(80 + k, -1, '0, 0);
      drive(3'b010, d, 1'b0);
    end
    check("t3_ch1_recovered", 32'(health_state[1]), 32'd0);

    // All-zero frame on ch0.
    d[0] = '0;
    drive(3'b001, d, 1'b0);
    check("t4_err_loss_only", 32'(error_code),      32'b0100);
    check("t4_ch0_susp",      32'(health_state[0]), 32'd1);

    // Clear together with another loss frame: the new error survives.
    drive(3'b001, d, 1'b1);
    check("t5_sticky_new_wins", 32'(sticky_code), 32'b0100);
    d[0] = mk_frame(90, -1, '0, 0);
    drive(3'b001, d, 1'b1);
    check("t5_sticky_cleared", 32'(sticky_code), 32'h0);

    // Put ch1 into FAULT, then reset asynchronously mid-cycle.
    for (int k = 0; k < FC; k++) begin
      d[1] = mk_frame(100 + k, -1, '0, 1);
      drive(3'b010, d, 1'b0);
    end
    check("t6_ch1_fault", 32'(health_state[1]), 32'd2);
    check("t6_irq_high",  32'(irq),             32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_states", 32'(health_state), 32'h3f);
    check("t6_async_irq",    32'(irq),          32'h0);
    check("t6_async_mask",   32'(fault_mask),   32'h7);
    check("t6_async_err",    32'(error_code),   32'h0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    d[0] = mk_frame(110, -1, '0, 0);
    d[1] = mk_frame(111, -1, '0, 0);
    d[2] = mk_frame(112, -1, '0, 0);
    drive(3'b111, d, 1'b0);
    check("t6_post_reset_recover", 32'(health_state), 32'h3f);

`ifdef FAULT_MON_STUCK_DETECT_EN
    for (int k = 0; k < RC; k++) begin
      d[0] = mk_frame(120 + k, -1, '0, 0);
      drive(3'b001, d, 1'b0);
    end
    d[0] = mk_frame(150, -1, '0, 0);
    for (int k = 0; k < SC; k++) drive(3'b001, d, 1'b0);
    check("t7_stuck_flag", 32'(stuck_flags[0]),  32'd1);
    check("t7_stuck_susp", 32'(health_state[0]), 32'd1);
    d[0] = mk_frame(151, -1, '0, 0);
    drive(3'b001, d, 1'b0);
    check("t7_stuck_clear", 32'(stuck_flags[0]), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
